// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Round-robin arbiter that owns the select of a shared 4:1 mux
//               and grants it to one requester at a time for bounded bursts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       out
);

  localparam logic [0:0] c_IDLE      = 1'b0;
  localparam logic [0:0] c_GRANT     = 1'b1;
  localparam logic [3:0] c_HOLD_LAST = 4'(HOLD - 1);

  logic [0:0] r_state, w_state_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_ptr,   w_ptr_nxt;
  logic [3:0] r_cnt,   w_cnt_nxt;

  logic       w_release;
  logic [1:0] w_base;
  logic [1:0] w_idx;
  logic [1:0] w_winner;
  logic       w_found;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A releasing owner re-arbitrates from owner+1, so a lone requester whose
  // burst expired wins again through the wrap of the search order.
  always_comb begin
    w_release = (r_state == c_GRANT) && (!req[r_owner] || (r_cnt >= c_HOLD_LAST));
    w_base    = w_release ? (r_owner + 2'd1) : r_ptr;
    w_winner  = 2'd0;
    w_found   = 1'b0;
    w_idx     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_idx = w_base + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_found) begin
          w_state_nxt = c_GRANT;
          w_owner_nxt = w_winner;
          w_cnt_nxt   = 4'd0;
        end
      end
      default: begin
        if (!w_release) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else begin
          w_ptr_nxt = r_owner + 2'd1;
          if (w_found) begin
            w_owner_nxt = w_winner;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = c_IDLE;
          end
        end
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    valid = (r_state == c_GRANT);
    sel   = r_owner;
    gnt   = valid ? (4'b0001 << r_owner) : 4'b0000;
    out   = valid & d[r_owner];
  end

endmodule

`default_nettype wire

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one 4-to-1 multiplexer among four requesters. It owns the 2-bit mux select and grants the path to one requester at a time, for a bounded burst. When the burst ends, ownership rotates so that no requester starves. It sits directly in front of the 4:1 mux datapath and drives its select lines.

## Interface
- HOLD, default 4: maximum consecutive cycles one requester may own the mux; legal range 1..15.
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- req  input  4  request vector; bit i set = requester i wants the mux.
- d  input  4  data bits; d[i] is requester i's input to the mux.
- gnt  output  4  one-hot grant; all zero when idle.
- sel  output  2  mux select; equals the index of the set gnt bit, holds last value when idle.
- valid  output  1  high while a grant is active (state GRANT).
- out  output  1  muxed data: d[sel] when valid, else 0 (combinational from registered sel/valid).

## Operation
- State machine, 2 states: IDLE, GRANT. Registers: state, owner[1:0] (drives sel), ptr[1:0] (highest-priority index), cnt[3:0].
- Priority search order from ptr: ptr, ptr+1, ptr+2, ptr+3 (mod 4, 2-bit wrap); first set req bit wins.
- IDLE: if req != 0, load owner with the winner, set cnt=0, go to GRANT. Otherwise stay in IDLE.
- GRANT, continue: req[owner]=1 and cnt < HOLD-1 -> stay, cnt+1.
- GRANT, release: req[owner]=0 or cnt == HOLD-1. Set ptr = owner+1 (wraps 3->0). Re-arbitrate in the same cycle using the new ptr; the request vector used is req with bit owner masked if req[owner]=0.
  - If a winner exists: owner<=winner, cnt<=0, stay in GRANT (back-to-back, no idle cycle).
  - If no winner: go to IDLE.
- The sole remaining requester whose burst expired while still requesting is re-granted through the wrap of the search order; a fresh burst starts with cnt=0.
- gnt = valid ? (1 << owner) : 4'b0000. At most one gnt bit is ever set.
- A request dropped mid-burst is a release and is not an error. Requests arriving mid-burst wait; they are not queued beyond the level of req.

## Timing
- Reset (rst=1 at clock edge): state=IDLE, owner=0, ptr=0, cnt=0. Hence gnt=0000, sel=00, valid=0, out=0 from the cycle after the reset edge.
- rst wins over every other condition, including mid-burst. The grant drops on the next edge.
- Grant latency: req sampled at edge N in IDLE -> gnt/valid high after edge N (visible in cycle N+1).
- Max burst: exactly HOLD cycles of gnt for a continuously requesting owner. HOLD=1 gives one-cycle round-robin.
- Handover: the release edge and the new grant coincide. gnt changes directly from one one-hot value to another with zero gap.
- Release on req drop: the owner's gnt falls on the first edge where its req is sampled low. That is one cycle of lag.
- out follows d combinationally within the same cycle while valid.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,… and each gets HOLD cycles.

## Test plan
- Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, sel=00, valid=0, out=0 throughout; rst=0 -> gnt=0001 one cycle later.
- Single requester, HOLD=4: req=0100 held, d=0100 -> gnt=0100, sel=10, out=1. Bursts repeat back-to-back, re-granted every 4 cycles with no gap; gnt stays 0100.
- Full contention, HOLD=4: req=1111 from reset -> gnt sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001…; sel 0,1,2,3 accordingly.
- Early release: req=0011, owner 0. Drop req[0] after 2 granted cycles -> gnt 0001 for 2 cycles, then 0010 on the next edge with no idle cycle.
- Wrap-around priority: owner 3 releases (ptr->0) with req=1010 -> next gnt=0010 (index 1), not 1000. Then req=0000 -> IDLE, valid=0, out=0, sel holds 01.
- Reset mid-burst: rst=1 during cycle 2 of a 4-cycle burst -> gnt=0000 after that edge; after rst=0, arbitration restarts at ptr=0.
